prog_loader: RTL and testbench

- Writer side of the instruction-memory path: the core's fetch stage only reads program memory, and this block fills it.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and issues single-cycle word writes to program memory at byte addresses 0, 4, 8, ...
- Holds the core stalled (cpu_hold) from reset until a load completes, so fetch never reads a partially written image.

---
 rtl/prog_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// prog_loader
// Program-memory writer: gathers a byte stream into little-endian 32-bit
// instruction words and writes them to byte addresses 0, 4, 8, ...
// cpu_hold keeps the core stalled from reset until a load has completed.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [63:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Largest word count that still fits in program memory.
  localparam logic [ADDR_WIDTH:0] C_MAX_CNT = (ADDR_WIDTH+1)'(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] C_IDX_ONE = (ADDR_WIDTH+1)'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_FINISH  = 3'd3,
    S_CHECK   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
  logic [ADDR_WIDTH:0]   idx_q,   idx_d;
  logic [1:0]            bcnt_q,  bcnt_d;
  logic [31:0]           word_q,  word_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic                  error_q, error_d;
  logic                  hold_q,  hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q,   xor_d;
`endif

  // State and datapath registers; a low rst_n returns everything to its idle values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Next-state logic plus the byte_ready / mem_we strobes decoded from the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    hold_d     = hold_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    byte_ready = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Any accepted request invalidates the current image until it completes.
          cnt_d  = word_count;
          idx_d  = '0;
          bcnt_d = '0;
          word_d = '0;
          hold_d = 1'b1;
          done_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d  = '0;
`endif
          if (word_count > C_MAX_CNT) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            error_d = 1'b0;
            busy_d  = 1'b1;
            if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_FINISH;
`endif
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
      end

      S_COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_in;
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ byte_in;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        mem_we = 1'b1;
        idx_d  = idx_q + C_IDX_ONE;
        if ((idx_q + C_IDX_ONE) == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_FINISH;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_in == xor_q) begin
            state_d = S_FINISH;
          end else begin
            // Corrupt image: report failure and keep the core stalled.
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hold_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write address is the word index scaled to bytes; bits above it stay zero.
  assign mem_addr  = {{(64-ADDR_WIDTH-2){1'b0}}, idx_q[ADDR_WIDTH-1:0], 2'b00};
  assign mem_wdata = word_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//------------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader: directed and randomized loads compared
// against a word-assembly reference model built from the sent byte list.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  localparam int AW = 8;
  localparam int MW = 256;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_in    = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [63:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  prog_loader #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_pass = 0;
  int           lat_g = 0;
  logic [7:0]   src[$];
  logic [95:0]  exp_q[$];
  logic [95:0]  got_q[$];

  // Capture every write strobe as {address, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: word w is bytes 4w..4w+3 weighted little-endian, at byte address 4w.
  task automatic build_exp();
    logic [31:0] data;
    logic [7:0]  x;
    exp_q.delete();
    x = 8'h00;
    for (int w = 0; w < src.size() / 4; w++) begin
      data = 32'h0;
      for (int k = 0; k < 4; k++) data = data + (32'(src[4*w+k]) << (8*k));
      exp_q.push_back({64'(4*w), data});
    end
    for (int i = 0; i < src.size(); i++) x = x ^ src[i];
`ifdef LOADER_CHECKSUM_EN
    src.push_back(x);
`endif
  endtask

  task automatic rand_src(input int nwords);
    src.delete();
    for (int i = 0; i < 4*nwords; i++) src.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_start(input int cnt);
    @(negedge clk);
    start = 1'b1;
    word_count = (AW+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Source holds each byte until it is accepted. mode 0: always valid, 1: toggle, 2: random.
  task automatic send(input int nbytes, input int mode);
    int i = 0;
    int t = 0;
    while (i < nbytes && t < 4000) begin
      byte_in = src[i];
      if (mode == 0)      byte_valid = 1'b1;
      else if (mode == 1) byte_valid = (t[0] == 1'b0);
      else                byte_valid = 1'($urandom_range(0, 1));
      t++;
      if (byte_valid && byte_ready) i++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("send_bound", 96'(t < 4000), 96'(1));
  endtask

  task automatic wait_end();
    lat_g = 0;
    while (!(done || error) && lat_g < 3000) begin
      @(negedge clk);
      lat_g++;
    end
    check("end_timeout", 96'(lat_g < 3000), 96'(1));
  endtask

  task automatic run_load(input string tag, input int nw, input int mode);
    got_q.delete();
    do_start(nw);
    fork
      send(src.size(), mode);
      wait_end();
    join
    check({tag, "_nwr"}, 96'(got_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_done"}, 96'(done), 96'(1));
    check({tag, "_err"},  96'(error), 96'(0));
    check({tag, "_hold"}, 96'(cpu_hold), 96'(0));
    check({tag, "_busy"}, 96'(busy), 96'(0));
    check({tag, "_rdy"},  96'(byte_ready), 96'(0));
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_hold",  96'(cpu_hold), 96'(1));
    check("rst_done",  96'(done), 96'(0));
    check("rst_busy",  96'(busy), 96'(0));
    check("rst_err",   96'(error), 96'(0));
    check("rst_rdy",   96'(byte_ready), 96'(0));
    check("rst_we",    96'(mem_we), 96'(0));
    check("rst_addr",  96'(mem_addr), 96'(0));
    check("rst_wdata", 96'(mem_wdata), 96'(0));

    // Directed two-word load, valid always high
    src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_exp();
    run_load("dir", 2, 0);
    check("dir_w0_const", got_q.size() > 0 ? got_q[0] : 96'hx, {64'h0, 32'h0000_0013});
    check("dir_w1_const", got_q.size() > 1 ? got_q[1] : 96'hx, {64'h4, 32'h0010_0093});
`ifdef LOADER_CHECKSUM_EN
    check("dir_latency", 96'(lat_g), 96'(12));
`else
    check("dir_latency", 96'(lat_g), 96'(11));
`endif

    // Same image with valid toggling every cycle
    src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_exp();
    run_load("tog", 2, 1);

    // Randomized loads
    for (int r = 0; r < 5; r++) begin
      int nw;
      int md;
      nw = $urandom_range(1, 6);
      md = $urandom_range(0, 2);
      rand_src(nw);
      build_exp();
      run_load($sformatf("rnd%0d", r), nw, md);
    end

    // Overflow request: rejected with no writes
    got_q.delete();
    do_start(MW + 1);
    repeat (5) @(negedge clk);
    check("ovf_err",  96'(error), 96'(1));
    check("ovf_hold", 96'(cpu_hold), 96'(1));
    check("ovf_busy", 96'(busy), 96'(0));
    check("ovf_done", 96'(done), 96'(0));
    check("ovf_nwr",  96'(got_q.size()), 96'(0));

    // Zero-length load
    src.delete();
    build_exp();
    run_load("zero", 0, 0);

    // Reset in the middle of a three-word load
    rand_src(3);
    build_exp();
    got_q.delete();
    do_start(3);
    send(6, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_hold",  96'(cpu_hold), 96'(1));
    check("mid_busy",  96'(busy), 96'(0));
    check("mid_done",  96'(done), 96'(0));
    check("mid_rdy",   96'(byte_ready), 96'(0));
    check("mid_addr",  96'(mem_addr), 96'(0));
    check("mid_wdata", 96'(mem_wdata), 96'(0));
    repeat (8) @(negedge clk);
    check("mid_nwr", 96'(got_q.size()), 96'(1));
    check("mid_w0", got_q.size() > 0 ? got_q[0] : 96'hx, exp_q[0]);
    rand_src(2);
    build_exp();
    run_load("restart", 2, 2);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum then bad checksum
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_exp();
    run_load("cs_ok", 1, 0);
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_exp();
    src[4] = 8'h01;
    got_q.delete();
    do_start(1);
    fork
      send(src.size(), 0);
      wait_end();
    join
    check("cs_bad_err",  96'(error), 96'(1));
    check("cs_bad_hold", 96'(cpu_hold), 96'(1));
    check("cs_bad_done", 96'(done), 96'(0));
    check("cs_bad_busy", 96'(busy), 96'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
